// File: rtl/mul_seq_pkg.sv
// Shared definitions for the EX-stage multiply sequencer: ALU32 control
// encodings and the sequencer FSM state encoding.
package mul_seq_pkg;

  // Operand width; the sequencer and ALU32 are both built around 32 bits.
  localparam int XLEN = 32;

  // ALUctl encodings understood by ALU32.
  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;

  // Sequencer FSM state encoding.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/mul_seq_alu32.sv
// ALU32: the shared 32-bit integer ALU of the EX stage. The multiply
// sequencer borrows it as its add engine while the pipeline is stalled.
module ALU32
  import mul_seq_pkg::*;
(
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            ovf
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  // Adder and subtractor results shared by ADD, SUB and the overflow logic.
  always_comb begin
    sum  = a + b;
    diff = a - b;
  end

  // Operation select; signed overflow is only meaningful for ADD and SUB.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_ctl)
      ALUCTL_AND: result = a & b;
      ALUCTL_OR:  result = a | b;
      ALUCTL_ADD: begin
        result = sum;
        ovf    = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      ALUCTL_SUB: begin
        result = diff;
        ovf    = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      ALUCTL_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default:    result = '0;
    endcase
  end

  // Zero flag over whichever result was selected.
  always_comb begin
    zero = (result == '0);
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle 32x32->64 multiply sequencer for the EX stage.
// Radix-2 shift-add, one ALU32 add per iteration. Signed operands are
// reduced to magnitudes up front and the product is negated afterwards.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic            signed_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result_lo,
  output logic [XLEN-1:0] result_hi,
  output logic            ovf
);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [4:0]      cnt;
  logic            sgn;
  logic            neg;

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_sum;
  logic            alu_zero_unused;
  logic            alu_ovf_unused;
  logic            cout;

  // Status outputs: busy covers every non-idle state; a start seen in IDLE
  // stalls the pipeline in the same cycle it is presented.
  always_comb begin
    busy      = (state != ST_IDLE);
    stall_req = busy | (start & (state == ST_IDLE));
  end

  // Next-state logic; flush wins over every transition.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = start ? ST_PREP : ST_IDLE;
      ST_PREP: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = (cnt == 5'd31) ? ST_FIX : ST_RUN;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU operands are only live in RUN; elsewhere they are held at zero so
  // the shared adder does not toggle needlessly.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state == ST_RUN) begin
      alu_a = hi;
      alu_b = lo[0] ? mcand : '0;
    end
  end

  ALU32 u_alu (
    .alu_ctl (ALUCTL_ADD),
    .a       (alu_a),
    .b       (alu_b),
    .result  (alu_sum),
    .zero    (alu_zero_unused),
    .ovf     (alu_ovf_unused)
  );

  // Unsigned carry out of the 32-bit add, recovered from the operand and
  // sum MSBs because ALU32 does not export its carry.
  always_comb begin
    cout = (alu_a[XLEN-1] & alu_b[XLEN-1]) |
           ((alu_a[XLEN-1] | alu_b[XLEN-1]) & ~alu_sum[XLEN-1]);
  end

  // Datapath: operand capture, magnitude conversion, shift-add iterations
  // and final sign fix-up. A flush freezes the datapath for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      neg   <= 1'b0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= op_a;
            lo    <= op_b;
            sgn   <= signed_op;
          end
        end
        ST_PREP: begin
          if (sgn) begin
            mcand <= mcand[XLEN-1] ? (~mcand + 32'd1) : mcand;
            lo    <= lo[XLEN-1] ? (~lo + 32'd1) : lo;
            neg   <= mcand[XLEN-1] ^ lo[XLEN-1];
          end else begin
            neg   <= 1'b0;
          end
          hi  <= '0;
          cnt <= '0;
        end
        ST_RUN: begin
          hi  <= {cout, alu_sum[XLEN-1:1]};
          lo  <= {alu_sum[0], lo[XLEN-1:1]};
          cnt <= cnt + 5'd1;
        end
        ST_FIX: begin
          if (neg) begin
            {hi, lo} <= ~{hi, lo} + 64'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers and the one-cycle done pulse; results hold until the
  // next operation completes, and a flushed DONE publishes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!flush && (state == ST_DONE)) begin
        done      <= 1'b1;
        result_lo <= lo;
        result_hi <= hi;
        ovf       <= sgn ? (hi != {XLEN{lo[XLEN-1]}}) : (hi != '0);
      end
    end
  end

endmodule
